// File: rtl/sdfa_pkg.sv
// ---------------------------------------------------------------------------
// sdfa_pkg
// Shared definitions for the LSTM weight-SRAM write loader.
//   W_SIZE_BIT : width of one weight (one SRAM lane)
//   LANES      : weights packed into one SRAM row
//   ADDR_BIT   : SRAM row-address width
//   ROW_BITS   : width of a row count, able to hold 0..2**ADDR_BIT
//   state_t    : loader FSM encoding
// ---------------------------------------------------------------------------
package sdfa_pkg;

    localparam int W_SIZE_BIT = 14;
    localparam int LANES      = 8;
    localparam int ADDR_BIT   = 8;
    localparam int ROW_BITS   = ADDR_BIT + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sdfa_lane_packer.sv
// ---------------------------------------------------------------------------
// sdfa_lane_packer
// Collects serial weights into one SRAM row. Beat k of a row lands in lane k
// (bits k*W_SIZE_BIT +: W_SIZE_BIT), so lane 0 holds the first beat.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   i_clr       : restart the row at lane 0 (row contents are kept, every
//                 lane is overwritten as the next row fills)
//   i_accept    : a beat transfers this cycle
//   i_data      : the beat
//   o_row       : packed row, stable between accepted beats
//   o_row_full  : combinational, high on the transfer that fills the last lane
// ---------------------------------------------------------------------------
module sdfa_lane_packer #(
    parameter int W_SIZE_BIT = 14,
    parameter int LANES      = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          i_clr,
    input  logic                          i_accept,
    input  logic [W_SIZE_BIT-1:0]         i_data,
    output logic [LANES*W_SIZE_BIT-1:0]   o_row,
    output logic                          o_row_full
);

    localparam int LANE_BIT = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_BIT-1:0] LAST_LANE = LANE_BIT'(LANES - 1);

    logic [LANE_BIT-1:0]         r_lane;
    logic [LANES*W_SIZE_BIT-1:0] r_row;

    assign o_row_full = i_accept && (r_lane == LAST_LANE);
    assign o_row      = r_row;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lane <= '0;
            r_row  <= '0;
        end else if (i_clr) begin
            r_lane <= '0;
        end else if (i_accept) begin
            // The lane counter wraps on its own after the last lane, so a
            // clear from the owner is only needed when a run restarts.
            r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + LANE_BIT'(1);
            for (int k = 0; k < LANES; k++) begin
                if (r_lane == LANE_BIT'(k)) begin
                    r_row[k*W_SIZE_BIT +: W_SIZE_BIT] <= i_data;
                end
            end
        end
    end

endmodule

// File: rtl/sdfa_wload_8.sv
// ---------------------------------------------------------------------------
// sdfa_wload_8
// Write-side loader for the 8-lane x 14-bit, 256-row LSTM weight SRAM.
// A START pulse in IDLE captures a base row and a row count; the loader then
// packs 8 streamed weights per row and writes each row for one cycle through
// the SRAM's active-low write port, bumping the row pointer modulo 256.
// After the last write it waits two cycles for the SRAM capture stage so the
// final row is readable when DONE pulses.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   START       : one-cycle run request, only honoured in IDLE
//   BASE_ADDR   : first row of the run
//   ROW_CNT     : rows in the run, 0..256 (larger values mean 256)
//   S_VALID/S_DATA/S_READY : weight stream handshake
//   WE          : SRAM write enable, active-low, low only in WRITE
//   ADDR_WRITE  : SRAM row address (the row pointer)
//   DIN         : SRAM row data (the packed row)
//   BUSY        : high whenever the FSM is not IDLE
//   DONE        : one-cycle completion pulse
// ---------------------------------------------------------------------------
module sdfa_wload_8 #(
    parameter int W_SIZE_BIT = sdfa_pkg::W_SIZE_BIT,
    parameter int LANES      = sdfa_pkg::LANES,
    parameter int ADDR_BIT   = sdfa_pkg::ADDR_BIT
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [ADDR_BIT-1:0]           BASE_ADDR,
    input  logic [ADDR_BIT:0]             ROW_CNT,
    input  logic                          S_VALID,
    input  logic [W_SIZE_BIT-1:0]         S_DATA,
    output logic                          S_READY,
    output logic                          WE,
    output logic [ADDR_BIT-1:0]           ADDR_WRITE,
    output logic [LANES*W_SIZE_BIT-1:0]   DIN,
    output logic                          BUSY,
    output logic                          DONE
);

    import sdfa_pkg::*;

    localparam int RCNT_W = ADDR_BIT + 1;
    localparam logic [RCNT_W-1:0] FULL_ROWS = RCNT_W'(1) << ADDR_BIT;

    // Requests beyond the SRAM depth would revisit rows, so they are capped
    // at one full pass.
    function automatic logic [RCNT_W-1:0] clamp_rows(input logic [RCNT_W-1:0] req);
        return (req > FULL_ROWS) ? FULL_ROWS : req;
    endfunction

    state_t                      r_state;
    state_t                      w_next;
    logic [ADDR_BIT-1:0]         r_ptr;
    logic [RCNT_W-1:0]           r_rows_left;
    logic                        r_flush;

    logic                        w_start;
    logic                        w_accept;
    logic                        w_clr;
    logic                        w_row_full;
    logic [RCNT_W-1:0]           w_rows_req;
    logic [LANES*W_SIZE_BIT-1:0] w_row;

    assign w_start    = (r_state == ST_IDLE) && START;
    assign w_rows_req = clamp_rows(ROW_CNT);
    assign S_READY    = (r_state == ST_FILL);
    assign w_accept   = S_VALID && S_READY;
    assign w_clr      = w_start || (r_state == ST_WRITE);

    assign WE         = (r_state != ST_WRITE);
    assign BUSY       = (r_state != ST_IDLE);
    assign DONE       = (r_state == ST_DONE);
    assign ADDR_WRITE = r_ptr;
    assign DIN        = w_row;

    sdfa_lane_packer #(
        .W_SIZE_BIT (W_SIZE_BIT),
        .LANES      (LANES)
    ) u_packer (
        .CLK        (CLK),
        .RST        (RST),
        .i_clr      (w_clr),
        .i_accept   (w_accept),
        .i_data     (S_DATA),
        .o_row      (w_row),
        .o_row_full (w_row_full)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_next = (w_rows_req == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_row_full) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // rows_left still counts the row being written this cycle.
                w_next = (r_rows_left == RCNT_W'(1)) ? ST_FLUSH : ST_FILL;
            end
            ST_FLUSH: begin
                if (r_flush) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_rows_left <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_ptr       <= BASE_ADDR;
                r_rows_left <= w_rows_req;
            end else if (r_state == ST_WRITE) begin
                // Natural ADDR_BIT-wide overflow gives the modulo-256 wrap.
                r_ptr       <= r_ptr + ADDR_BIT'(1);
                r_rows_left <= r_rows_left - RCNT_W'(1);
            end
            // r_flush marks the second of the two FLUSH cycles.
            r_flush <= (r_state == ST_FLUSH) ? ~r_flush : 1'b0;
        end
    end

endmodule

// File: tb/tb_sdfa_wload_8.sv
module tb_sdfa_wload_8;

    localparam int W  = 14;
    localparam int L  = 8;
    localparam int RW = L * W;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [7:0]    BASE_ADDR = '0;
    logic [8:0]    ROW_CNT = '0;
    logic          S_VALID = 1'b0;
    logic [W-1:0]  S_DATA = '0;
    logic          S_READY;
    logic          WE;
    logic [7:0]    ADDR_WRITE;
    logic [RW-1:0] DIN;
    logic          BUSY;
    logic          DONE;

    sdfa_wload_8 dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .ROW_CNT    (ROW_CNT),
        .S_VALID    (S_VALID),
        .S_DATA     (S_DATA),
        .S_READY    (S_READY),
        .WE         (WE),
        .ADDR_WRITE (ADDR_WRITE),
        .DIN        (DIN),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]    addr;
        logic [RW-1:0] row;
    } wr_t;

    wr_t           exp_q[$];
    logic [W-1:0]  beat_q[$];
    logic [RW-1:0] mem [256];
    int            wr_count [256];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            we_low = 0;
    int            busy_bad = 0;
    bit            chk_busy = 1'b0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Behavioural SRAM: a row presented with WE low is captured at the edge.
    always @(posedge CLK) begin
        if (WE === 1'b0) mem[ADDR_WRITE] <= DIN;
    end

    // Monitor: every WE-low cycle must match the next expected write.
    always @(negedge CLK) begin
        if (!RST) begin
            if (WE === 1'b0) begin
                we_low++;
                wr_count[ADDR_WRITE]++;
                check("ready_in_write", RW'(S_READY), RW'(0));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0h, required no write", ADDR_WRITE);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", RW'(ADDR_WRITE), RW'(e.addr));
                    check("wr_data", DIN, e.row);
                end
            end
            if (DONE === 1'b1) check("ready_in_done", RW'(S_READY), RW'(0));
            if (chk_busy && BUSY !== 1'b1) busy_bad++;
        end
    end

    // Drives beats from beat_q at negedges with random gaps; a beat is
    // consumed when valid is offered while ready is high.
    task automatic feed(input int nbeats, input int gap_pct, input int sneak_idx,
                        input logic [7:0] sneak_base);
        int idx = 0;
        int guard = 0;
        bit sneaked = 1'b0;
        while (idx < nbeats) begin
            bit v;
            v = ($urandom_range(99) >= gap_pct);
            S_VALID = v;
            S_DATA  = v ? beat_q[idx] : W'($urandom);
            if (!sneaked && sneak_idx >= 0 && idx == sneak_idx) begin
                START     = 1'b1;
                BASE_ADDR = sneak_base;
                ROW_CNT   = 9'd5;
                sneaked   = 1'b1;
            end else begin
                START = 1'b0;
            end
            if (v && S_READY === 1'b1) idx++;
            @(negedge CLK);
            guard++;
            if (guard > nbeats * 20 + 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL feed_timeout: accepted %0d, required %0d beats", idx, nbeats);
                break;
            end
        end
        S_VALID = 1'b0;
        START   = 1'b0;
    endtask

    // Counts rising edges from the last action edge until DONE is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (DONE !== 1'b1 && n < 30) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic run_job(input logic [7:0] base, input logic [8:0] cnt, input int gap_pct,
                           input bit seq, input int sneak_idx, input int abort_beats);
        int  rows;
        int  nb;
        int  n;
        int  w0;
        int  done_rows;
        wr_t e;
        wr_t lst[$];
        rows = (cnt > 9'd256) ? 256 : int'(cnt);
        beat_q.delete();
        for (int i = 0; i < rows * L; i++)
            beat_q.push_back(seq ? W'(i + 1) : W'($urandom));
        done_rows = (abort_beats >= 0) ? abort_beats / L : rows;
        nb        = (abort_beats >= 0) ? abort_beats : rows * L;
        for (int r = 0; r < done_rows; r++) begin
            e.addr = 8'(int'(base) + r);
            e.row  = '0;
            for (int l = 0; l < L; l++) e.row[l*W +: W] = beat_q[r*L + l];
            exp_q.push_back(e);
            lst.push_back(e);
        end
        w0 = we_low;
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = base; ROW_CNT = cnt;
        @(negedge CLK);
        START = 1'b0; BASE_ADDR = $urandom; ROW_CNT = $urandom;
        busy_bad = 0;
        chk_busy = 1'b1;
        if (rows == 0) begin
            wait_done(n);
            check("zero_done_within_2", RW'(n <= 2), RW'(1));
        end else begin
            feed(nb, gap_pct, sneak_idx, base ^ 8'h55);
            if (abort_beats < 0) begin
                wait_done(n);
                check("done_latency", RW'(n), RW'(4));
            end
        end
        chk_busy = 1'b0;
        if (abort_beats >= 0) begin
            RST = 1'b1;
            @(negedge CLK);
            check("rst_we", RW'(WE), RW'(1));
            check("rst_busy", RW'(BUSY), RW'(0));
            check("rst_ready", RW'(S_READY), RW'(0));
            check("rst_done", RW'(DONE), RW'(0));
            check("rst_din", DIN, RW'(0));
            RST = 1'b0;
        end else begin
            check("busy_held", RW'(busy_bad), RW'(0));
            @(negedge CLK);
            check("done_pulse", RW'(DONE), RW'(0));
            check("idle_busy", RW'(BUSY), RW'(0));
        end
        check("rows_pending", RW'(exp_q.size()), RW'(0));
        check("we_low_cycles", RW'(we_low - w0), RW'(done_rows));
        foreach (lst[i]) check("sram_row", mem[lst[i].addr], lst[i].row);
        exp_q.delete();
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            wr_count[i] = 0;
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_we", RW'(WE), RW'(1));
        check("reset_ready", RW'(S_READY), RW'(0));
        check("reset_busy", RW'(BUSY), RW'(0));
        check("reset_done", RW'(DONE), RW'(0));
        check("reset_addr", RW'(ADDR_WRITE), RW'(0));
        check("reset_din", DIN, RW'(0));
        RST = 1'b0;

        run_job(8'h10, 9'd1, 0, 1'b1, -1, -1);     // single row, beats 1..8
        run_job(8'hFF, 9'd2, 0, 1'b0, -1, -1);     // wrap 0xFF -> 0x00
        run_job(8'h30, 9'd3, 40, 1'b0, -1, -1);    // gaps in S_VALID
        run_job(8'h20, 9'd0, 0, 1'b0, -1, -1);     // zero length

        for (int i = 0; i < 256; i++) wr_count[i] = 0;
        run_job(8'h80, 9'd256, 0, 1'b0, -1, -1);   // full length
        bad = 0;
        for (int i = 0; i < 256; i++) if (wr_count[i] != 1) bad++;
        check("full_cover_rows_not_once", RW'(bad), RW'(0));

        run_job(8'h07, 9'd400, 10, 1'b0, -1, -1);  // clamped to 256
        run_job(8'h50, 9'd2, 20, 1'b0, 3, -1);     // START while busy
        run_job(8'h40, 9'd3, 0, 1'b0, -1, 21);     // reset after 5 beats of row 2
        run_job(8'h42, 9'd1, 30, 1'b0, -1, -1);    // rewrite row 0x42 from lane 0

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
